// File: rtl/mmio_uart_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mmio_uart_gpio                                             |
// | Description : MMIO peripheral with a posted TX byte FIFO for the serial  |
// |               transmitter, a GPIO output register with set/clear, and a  |
// |               readable status word carrying a sticky error flag.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package mmio_uart_gpio_pkg;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } mem_write_width_t;
endpackage

module mmio_uart_gpio
  import mmio_uart_gpio_pkg::*;
#(
  parameter logic [31:0]           BASE_ADDR  = 32'h0003_0000,
  parameter int                    FIFO_DEPTH = 8,
  parameter int                    GPIO_WIDTH = 2,
  parameter logic [GPIO_WIDTH-1:0] GPIO_RESET = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mmio_enable,
  input  logic                  mmio_write,
  input  logic [31:0]           mmio_addr,
  input  mem_write_width_t      mmio_width,
  input  logic [31:0]           mmio_w_data,
  output logic [31:0]           mmio_r_data,
  output logic                  mmio_complete,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [GPIO_WIDTH-1:0] gpio_out
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam logic [c_ptr_w:0]  c_ptr_one = 1;
  localparam logic [31:0]       c_off_tx     = 32'h00;
  localparam logic [31:0]       c_off_status = 32'h04;
  localparam logic [31:0]       c_off_gpio   = 32'h08;
  localparam logic [31:0]       c_off_set    = 32'h0C;
  localparam logic [31:0]       c_off_clr    = 32'h10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [c_ptr_w:0]      r_wptr;
  logic [c_ptr_w:0]      r_rptr;
  logic                  r_err;
  logic [GPIO_WIDTH-1:0] r_gpio;
  logic [31:0]           r_rdata;

  logic [31:0]           w_offset;
  logic                  w_sel_tx, w_sel_status, w_sel_gpio, w_sel_set, w_sel_clr;
  logic [c_lvl_w-1:0]    w_level;
  logic                  w_full, w_empty;
  logic                  w_push_req, w_blocked, w_accept, w_complete;
  logic                  w_push, w_pop, w_err_set, w_err_clr;
  logic [31:0]           w_status;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  // Only the low data bits reach a register; the rest is intentionally dropped.
  assign w_unused = &{1'b0, mmio_w_data};

  assign w_offset     = mmio_addr - BASE_ADDR;
  assign w_sel_tx     = (w_offset == c_off_tx);
  assign w_sel_status = (w_offset == c_off_status);
  assign w_sel_gpio   = (w_offset == c_off_gpio);
  assign w_sel_set    = (w_offset == c_off_set);
  assign w_sel_clr    = (w_offset == c_off_clr);

  // Pointers carry one extra wrap bit, so their difference is the level.
  assign w_level  = r_wptr - r_rptr;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (w_level == c_lvl_w'(FIFO_DEPTH));
  assign tx_valid = ~w_empty;
  assign tx_data  = r_mem[r_rptr[c_ptr_w-1:0]];

  // Only a byte push into a full FIFO has to wait; every other access is taken.
  assign w_push_req = mmio_write && w_sel_tx && (mmio_width == write_byte);
  assign w_blocked  = w_push_req && w_full;
  assign w_push     = w_accept && w_push_req;
  assign w_pop      = tx_valid && tx_ready;
  assign w_err_set  = w_accept && mmio_write && w_sel_tx && (mmio_width != write_byte);
  assign w_err_clr  = w_accept && mmio_write && w_sel_status;

  // Status word and read-data mux, sampled at the accepting edge.
  always_comb begin
    w_status                = '0;
    w_status[c_lvl_w-1:0]   = w_level;
    w_status[16]            = w_full;
    w_status[17]            = w_empty;
    w_status[18]            = w_empty && !tx_valid;
    w_status[19]            = r_err;
    w_rdata                 = '0;
    if (!mmio_write) begin
      if (w_sel_status) begin
        w_rdata = w_status;
      end else if (w_sel_gpio) begin
        w_rdata[GPIO_WIDTH-1:0] = r_gpio;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: accept in IDLE, pulse completion in RESP.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mmio_enable && !w_blocked) begin
          w_accept     = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_complete   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign mmio_complete = w_complete;
  assign mmio_r_data   = w_complete ? r_rdata : '0;
  assign gpio_out      = r_gpio;

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr[c_ptr_w-1:0]] <= mmio_w_data[7:0];
    end
  end

  // FIFO pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
    end
  end

  // Sticky error flag, GPIO register and captured read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err   <= 1'b0;
      r_gpio  <= GPIO_RESET;
      r_rdata <= '0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
      if (w_accept && mmio_write) begin
        if (w_sel_gpio) begin
          r_gpio <= mmio_w_data[GPIO_WIDTH-1:0];
        end else if (w_sel_set) begin
          r_gpio <= r_gpio | mmio_w_data[GPIO_WIDTH-1:0];
        end else if (w_sel_clr) begin
          r_gpio <= r_gpio & ~mmio_w_data[GPIO_WIDTH-1:0];
        end
      end
      if (w_accept) begin
        r_rdata <= w_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mmio_uart_gpio                                          |
// | Description : Scoreboard bench for mmio_uart_gpio with a queue-based     |
// |               reference model of the FIFO, GPIO and error flag.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mmio_uart_gpio;
  import mmio_uart_gpio_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          GW    = 4;
  localparam logic [31:0] BASE  = 32'h0003_0000;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             mmio_enable = 1'b0;
  logic             mmio_write = 1'b0;
  logic [31:0]      mmio_addr = '0;
  mem_write_width_t mmio_width = write_word;
  logic [31:0]      mmio_w_data = '0;
  logic [31:0]      mmio_r_data;
  logic             mmio_complete;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [GW-1:0]    gpio_out;

  always #5 clock = ~clock;

  mmio_uart_gpio #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .GPIO_WIDTH(GW),
    .GPIO_RESET('0)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mmio_enable  (mmio_enable),
    .mmio_write   (mmio_write),
    .mmio_addr    (mmio_addr),
    .mmio_width   (mmio_width),
    .mmio_w_data  (mmio_w_data),
    .mmio_r_data  (mmio_r_data),
    .mmio_complete(mmio_complete),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .gpio_out     (gpio_out)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        is_push;
    logic [7:0]  b;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [7:0]  tx_q[$];
  logic [GW-1:0] m_gpio = '0;
  logic        m_err = 1'b0;
  bit          rand_ready = 1'b0;
  bit          ready_val = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read value from the register map and the model state.
  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] r;
    int          lvl;
    r   = '0;
    lvl = tx_q.size();
    if (off == 32'h4) begin
      r = (32'(m_err) << 19) | (32'(lvl == 0) << 18) | (32'(lvl == 0) << 17)
        | (32'(lvl == DEPTH) << 16) | 32'(lvl);
    end else if (off == 32'h8) begin
      r = 32'(m_gpio);
    end
    return r;
  endfunction

  // Transmitter ready: random or forced, changed shortly after each edge.
  always @(posedge clock) begin
    #2;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Monitor: retire completed accesses and follow the byte stream.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mmio_complete) begin
        if (sb.size() == 0) begin
          check("unexpected_complete", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", mmio_r_data, mon_e.rdata);
          if (mon_e.is_push) tx_q.push_back(mon_e.b);
        end
      end else begin
        check("rdata_zero_when_idle", mmio_r_data, 32'd0);
      end
      check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      if (tx_valid && tx_q.size() != 0) begin
        check("tx_data", 32'(tx_data), 32'(tx_q[0]));
        if (tx_ready) void'(tx_q.pop_front());
      end
    end
  end

  // One access; lat < 0 derives the expected latency from the model.
  task automatic access(input bit wr, input logic [31:0] addr, input mem_write_width_t w,
                        input logic [31:0] data, input int lat);
    exp_t        e;
    int          n;
    int          exp_lat;
    logic [31:0] off;
    off       = addr - BASE;
    e.rdata   = '0;
    e.is_push = 1'b0;
    e.b       = data[7:0];
    exp_lat   = 1;
    if (!wr) begin
      e.rdata = model_read(off);
    end else begin
      case (off)
        32'h00: begin
          if (w == write_byte) begin
            e.is_push = 1'b1;
            if (tx_q.size() == DEPTH) exp_lat = -1;
          end else begin
            m_err = 1'b1;
          end
        end
        32'h04: m_err = 1'b0;
        32'h08: m_gpio = data[GW-1:0];
        32'h0C: m_gpio = m_gpio | data[GW-1:0];
        32'h10: m_gpio = m_gpio & ~data[GW-1:0];
        default: ;
      endcase
    end
    if (lat >= 0) exp_lat = lat;
    sb.push_back(e);
    mmio_enable = 1'b1;
    mmio_write  = wr;
    mmio_addr   = addr;
    mmio_width  = w;
    mmio_w_data = data;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mmio_complete && n < 60);
    if (!mmio_complete) begin
      check("complete_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
    end else if (exp_lat >= 0) begin
      check("latency", 32'(n - 1), 32'(exp_lat));
    end
    @(posedge clock);
    #1;
    mmio_enable = 1'b0;
    check("gpio_out", 32'(gpio_out), 32'(m_gpio));
  endtask

  task automatic model_reset();
    tx_q.delete();
    sb.delete();
    m_gpio = '0;
    m_err  = 1'b0;
  endtask

  task automatic release_reset();
    #10;
    reset_n = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #(400_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      off;
    mem_write_width_t w;
    bit               wr;
    // Reset state.
    #12;
    check("reset_gpio", 32'(gpio_out), 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_complete", 32'(mmio_complete), 32'd0);
    release_reset();
    check("status_after_reset", model_read(32'h4), 32'h0006_0000);
    access(1'b0, BASE + 32'h4, write_word, '0, 1);

    // Fill the FIFO with the transmitter stalled, then stall a ninth push.
    ready_val = 1'b0;
    for (int i = 0; i < DEPTH; i++) access(1'b1, BASE, write_byte, 32'h41 + i, 1);
    access(1'b0, BASE + 32'h4, write_word, '0, 1);
    fork
      access(1'b1, BASE, write_byte, 32'h49, 5);
      begin
        repeat (3) @(posedge clock);
        ready_val = 1'b1;
        @(posedge clock);
        ready_val = 1'b0;
      end
    join
    access(1'b0, BASE + 32'h4, write_word, '0, 1);
    ready_val = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    access(1'b0, BASE + 32'h4, write_word, '0, 1);

    // Streaming with the transmitter always ready.
    for (int i = 0; i < 6; i++) begin
      access(1'b1, BASE, write_byte, 32'h60 + i, 1);
      access(1'b0, BASE + 32'h4, write_word, '0, 1);
    end

    // Non-byte writes to TX_DATA set the sticky error; a STATUS write clears it.
    access(1'b1, BASE, write_word, 32'h1234_5678, 1);
    access(1'b0, BASE + 32'h4, write_word, '0, 1);
    access(1'b1, BASE, write_halfword, 32'h0000_5678, 1);
    access(1'b1, BASE + 32'h4, write_word, 32'h0, 1);
    access(1'b0, BASE + 32'h4, write_word, '0, 1);

    // GPIO load / set / clear, readback and unmapped addresses.
    access(1'b1, BASE + 32'h08, write_word, 32'h5, 1);
    access(1'b1, BASE + 32'h0C, write_word, 32'hA, 1);
    access(1'b1, BASE + 32'h10, write_word, 32'h3, 1);
    check("gpio_after_clr", 32'(gpio_out), 32'hC);
    access(1'b0, BASE + 32'h08, write_word, '0, 1);
    access(1'b0, BASE + 32'h40, write_word, '0, 1);
    access(1'b1, BASE + 32'h40, write_word, 32'hFFFF_FFFF, 1);
    access(1'b0, BASE + 32'h14, write_word, '0, 1);

    // Randomized mix with a random transmitter.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: off = 32'h00;
        3:       off = 32'h04;
        4:       off = 32'h08;
        5:       off = 32'h0C;
        6:       off = 32'h10;
        7:       off = 32'h1C;
        8:       off = 32'h02;
        default: off = 32'hFFFF_FFFC;
      endcase
      w  = mem_write_width_t'(2'($urandom_range(0, 2)));
      wr = 1'($urandom_range(0, 1));
      if (off == 32'h00 && $urandom_range(0, 3) != 0) begin
        w  = write_byte;
        wr = 1'b1;
      end
      access(wr, BASE + off, w, $urandom, -1);
    end
    rand_ready = 1'b0;

    // Asynchronous reset while a push is stalled on a full FIFO.
    ready_val = 1'b0;
    access(1'b1, BASE + 32'h08, write_word, 32'hF, 1);
    while (tx_q.size() < DEPTH) access(1'b1, BASE, write_byte, $urandom, -1);
    mmio_enable = 1'b1;
    mmio_write  = 1'b1;
    mmio_addr   = BASE;
    mmio_width  = write_byte;
    mmio_w_data = 32'h77;
    repeat (3) @(posedge clock);
    #3;
    check("stall_no_complete", 32'(mmio_complete), 32'd0);
    check("stall_tx_valid", 32'(tx_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_tx_valid", 32'(tx_valid), 32'd0);
    check("async_reset_complete", 32'(mmio_complete), 32'd0);
    check("async_reset_gpio", 32'(gpio_out), 32'd0);
    mmio_enable = 1'b0;
    model_reset();
    release_reset();
    access(1'b0, BASE + 32'h4, write_word, '0, 1);

    // Asynchronous reset during the completion cycle.
    access(1'b1, BASE + 32'h08, write_word, 32'h9, 1);
    mmio_enable = 1'b1;
    mmio_write  = 1'b0;
    mmio_addr   = BASE + 32'h08;
    mmio_width  = write_word;
    @(posedge clock);
    #2;
    check("resp_complete", 32'(mmio_complete), 32'd1);
    check("resp_rdata", mmio_r_data, 32'h9);
    reset_n = 1'b0;
    #1;
    check("resp_reset_complete", 32'(mmio_complete), 32'd0);
    check("resp_reset_rdata", mmio_r_data, 32'd0);
    check("resp_reset_gpio", 32'(gpio_out), 32'd0);
    mmio_enable = 1'b0;
    model_reset();
    release_reset();
    access(1'b0, BASE + 32'h4, write_word, '0, 1);
    access(1'b0, BASE + 32'h8, write_word, '0, 1);

    repeat (4) @(posedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
